usbh_tx_data: RTL and testbench

Transmit-side data packetizer for the USB full-speed host. It drains payload bytes from the host TX FIFO (first-word-fall-through pop interface) and emits a complete DATA0/DATA1 packet as a UTMI-style byte stream to the SIE transmitter: PID byte, N payload bytes, then CRC16. It sits between the TX FIFO read port and the SIE line encoder, and is launched once per OUT/SETUP data stage by the transaction controller.

---
 rtl/usbh_pkg.sv | 18 +
 rtl/usbh_crc16.sv | 24 ++
 rtl/usbh_tx_data.sv | 175 +++++++++++++++++
 tb/tb_usbh_tx_data.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbh_pkg.sv
// Shared constants and types for the USB host transmit data path:
// DATA PIDs, CRC16 parameters and the packetizer state encoding.
package usbh_pkg;

  localparam logic [7:0]  PID_DATA0       = 8'hC3;
  localparam logic [7:0]  PID_DATA1       = 8'h4B;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_PID    = 3'd1,
    TX_DATA   = 3'd2,
    TX_CRC_LO = 3'd3,
    TX_CRC_HI = 3'd4
  } tx_state_e;

endpackage

// File: rtl/usbh_crc16.sv
// Combinational USB CRC16 byte update (x^16+x^15+x^2+1, reflected,
// LSB-first). Only present when USBH_TX_DATA_CRC_EN is defined; the
// other build leaves CRC generation to the SIE.
`ifdef USBH_TX_DATA_CRC_EN
import usbh_pkg::*;

module usbh_crc16 (
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  // Fold the byte into the low bits, then shift out eight bits LSB-first.
  always_comb begin
    logic [15:0] c;
    c = crc_i ^ {8'h00, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule
`endif

// File: rtl/usbh_tx_data.sv
// USB full-speed host transmit data packetizer. Sends PID, payload bytes
// drained from a first-word-fall-through FIFO, and (optionally) CRC16 as
// a UTMI-style byte stream.
//
// Build option USBH_TX_DATA_CRC_EN: when defined, CRC_LO/CRC_HI states and
// the CRC16 generator are included; otherwise the packet ends after the
// last payload byte (or after the PID for a zero-length packet).
//
// Handshake: a byte moves when utmi_txvalid_o & utmi_txready_i are both
// high at a rising clk_i; while txvalid is high and txready low the byte
// and txvalid hold, except on FIFO underrun where txvalid drops and the
// packet aborts. fifo_pop_o is asserted exactly on accepted payload bytes.
import usbh_pkg::*;

module usbh_tx_data #(
  parameter int LEN_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             data1_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [7:0]       fifo_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  output logic             fifo_flush_o,
  output logic [7:0]       utmi_data_o,
  output logic             utmi_txvalid_o,
  input  logic             utmi_txready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o,
  output logic [2:0]       dbg_state_o
);

  tx_state_e        state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             data1_q, data1_d;
  logic             done_q, done_d;

`ifdef USBH_TX_DATA_CRC_EN
  logic [15:0]      crc_q, crc_d, crc_upd;

  usbh_crc16 u_crc16 (
    .crc_i  (crc_q),
    .data_i (fifo_data_i),
    .crc_o  (crc_upd)
  );
`endif

  // Next-state and stream outputs. All outputs except done_o decode from
  // the current state, so an asynchronous reset clears them at once.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    data1_d        = data1_q;
    done_d         = 1'b0;
`ifdef USBH_TX_DATA_CRC_EN
    crc_d          = crc_q;
`endif
    utmi_txvalid_o = 1'b0;
    utmi_data_o    = 8'h00;
    fifo_pop_o     = 1'b0;
    fifo_flush_o   = 1'b0;
    underrun_o     = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (start_i) begin
          rem_d   = len_i;
          data1_d = data1_i;
`ifdef USBH_TX_DATA_CRC_EN
          crc_d   = CRC16_INIT;
`endif
          state_d = TX_PID;
        end
      end

      TX_PID: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = data1_q ? PID_DATA1 : PID_DATA0;
        if (utmi_txready_i) begin
          if (rem_q != '0) begin
            state_d = TX_DATA;
          end else begin
`ifdef USBH_TX_DATA_CRC_EN
            state_d = TX_CRC_LO;
`else
            state_d = TX_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

      TX_DATA: begin
        if (fifo_empty_i) begin
          // Starved mid-payload: abort, flush whatever is left upstream.
          underrun_o   = 1'b1;
          fifo_flush_o = 1'b1;
          state_d      = TX_IDLE;
        end else begin
          utmi_txvalid_o = 1'b1;
          utmi_data_o    = fifo_data_i;
          if (utmi_txready_i) begin
            fifo_pop_o = 1'b1;
`ifdef USBH_TX_DATA_CRC_EN
            crc_d      = crc_upd;
`endif
            if (rem_q != '0) begin
              rem_d = rem_q - 1'b1;
            end
            if (rem_q == LEN_W'(1)) begin
`ifdef USBH_TX_DATA_CRC_EN
              state_d = TX_CRC_LO;
`else
              state_d = TX_IDLE;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end

`ifdef USBH_TX_DATA_CRC_EN
      TX_CRC_LO: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_q[7:0];
        if (utmi_txready_i) begin
          state_d = TX_CRC_HI;
        end
      end

      TX_CRC_HI: begin
        utmi_txvalid_o = 1'b1;
        utmi_data_o    = ~crc_q[15:8];
        if (utmi_txready_i) begin
          state_d = TX_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // State, counter, PID select, CRC and done pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      rem_q   <= '0;
      data1_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef USBH_TX_DATA_CRC_EN
      crc_q   <= CRC16_INIT;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data1_q <= data1_d;
      done_q  <= done_d;
`ifdef USBH_TX_DATA_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign busy_o      = (state_q != TX_IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_usbh_tx_data.sv
// Self-checking bench for usbh_tx_data. Expected byte streams come from a
// bit-serial CRC16 reference and the packet format rules; a monitor pops
// and compares every accepted byte.
module tb_usbh_tx_data;

  localparam int LEN_W = 10;
`ifdef USBH_TX_DATA_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             data1_i = 1'b0;
  logic [LEN_W-1:0] len_i = '0;
  logic [7:0]       fifo_data_i = 8'h00;
  logic             fifo_empty_i = 1'b1;
  logic             fifo_pop_o;
  logic             fifo_flush_o;
  logic [7:0]       utmi_data_o;
  logic             utmi_txvalid_o;
  logic             utmi_txready_i = 1'b1;
  logic             busy_o;
  logic             done_o;
  logic             underrun_o;
  logic [2:0]       dbg_state_o;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];     // {is_payload, byte}
  logic [7:0] fifo_q[$];
  int rdy_mode = 0;         // 0 always ready, 1 toggle, 2 random
  logic tog = 1'b0;

  usbh_tx_data #(.LEN_W(LEN_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .data1_i        (data1_i),
    .len_i          (len_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_pop_o     (fifo_pop_o),
    .fifo_flush_o   (fifo_flush_o),
    .utmi_data_o    (utmi_data_o),
    .utmi_txvalid_o (utmi_txvalid_o),
    .utmi_txready_i (utmi_txready_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .underrun_o     (underrun_o),
    .dbg_state_o    (dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Ready driver
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0: utmi_txready_i = 1'b1;
      1: begin tog = ~tog; utmi_txready_i = tog; end
      default: utmi_txready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // FIFO model: pop seen at negedge takes effect just after the next edge
  always begin
    bit p;
    @(negedge clk_i);
    p = fifo_pop_o && rst_ni;
    @(posedge clk_i);
    #1;
    if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = fifo_empty_i ? 8'h00 : fifo_q[0];
  end

  // Monitor / scoreboard
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk_i) begin
    logic [8:0] e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !underrun_o) begin
        check("hold_valid", 32'(utmi_txvalid_o), 32'd1);
        check("hold_data", 32'(utmi_data_o), 32'(prev_data));
      end
      if (utmi_txvalid_o && utmi_txready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %02h required none", utmi_data_o);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(utmi_data_o), 32'(e[7:0]));
          check("pop_on_accept", 32'(fifo_pop_o), 32'(e[8]));
        end
      end else begin
        check("no_pop_without_accept", 32'(fifo_pop_o), 32'd0);
      end
      check("flush_eq_underrun", 32'(fifo_flush_o), 32'(underrun_o));
      prev_stall = utmi_txvalid_o && !utmi_txready_i;
      prev_data  = utmi_data_o;
    end
  end

  // Load FIFO and push the expected byte stream for one packet.
  task automatic prep(input int len, input bit d1, input int avail, input bit ramp, output bit ur);
    logic [7:0]  pl[$];
    logic [7:0]  b;
    logic [15:0] c;
    bit          fb;
    ur = (avail < len);
    for (int i = 0; i < avail; i++) begin
      b = ramp ? 8'(i) : 8'($urandom_range(0, 255));
      pl.push_back(b);
      fifo_q.push_back(b);
    end
    exp_q.push_back({1'b0, d1 ? 8'h4B : 8'hC3});
    for (int i = 0; i < (ur ? avail : len); i++) exp_q.push_back({1'b1, pl[i]});
    if (!ur && CRC_EN) begin
      c = 16'hFFFF;
      for (int i = 0; i < pl.size(); i++) begin
        for (int j = 0; j < 8; j++) begin
          fb = c[0] ^ pl[i][j];
          c  = c >> 1;
          if (fb) c = c ^ 16'hA001;
        end
      end
      c = ~c;
      exp_q.push_back({1'b0, c[7:0]});
      exp_q.push_back({1'b0, c[15:8]});
    end
  endtask

  // Run one packet to completion (done or underrun), with optional
  // stray start pulses while busy and an optional back-to-back start.
  task automatic send(input int len, input bit d1, input int avail, input bit ramp,
                      input bit poke, input bit started, input bit chain,
                      input int nlen, input bit nd1);
    bit ur;
    int cnt;
    int limit;
    bit fin;
    prep(len, d1, avail, ramp, ur);
    if (!started) begin
      @(negedge clk_i);
      #1;
      start_i = 1'b1;
      len_i   = LEN_W'(len);
      data1_i = d1;
    end
    @(posedge clk_i);
    #1 start_i = 1'b0;
    cnt   = 0;
    limit = 8 * len + 200;
    fin   = 1'b0;
    while (!fin && cnt < limit) begin
      @(negedge clk_i);
      cnt++;
      if (cnt == 1) begin
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("txvalid_pid", 32'(utmi_txvalid_o), 32'd1);
      end
      if (done_o || underrun_o) begin
        fin = 1'b1;
        if (ur) begin
          check("underrun_pulse", 32'(underrun_o), 32'd1);
          check("no_done_on_underrun", 32'(done_o), 32'd0);
          @(negedge clk_i);
          check("busy_after_underrun", 32'(busy_o), 32'd0);
          check("underrun_one_cycle", 32'(underrun_o), 32'd0);
          check("no_done_after_underrun", 32'(done_o), 32'd0);
        end else begin
          check("done_pulse", 32'(done_o), 32'd1);
          check("no_underrun", 32'(underrun_o), 32'd0);
          check("busy_at_done", 32'(busy_o), 32'd0);
          if (rdy_mode == 0) check("done_latency", 32'(cnt), 32'(CRC_EN ? len + 4 : len + 2));
        end
        check("bytes_left", 32'(exp_q.size()), 32'd0);
      end else if (poke) begin
        #1;
        start_i = 1'($urandom_range(0, 1));
        data1_i = 1'($urandom_range(0, 1));
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done/underrun in %0d cycles required completion", limit);
      exp_q.delete();
      fifo_q.delete();
    end
    #1 start_i = 1'b0;
    if (chain && fin && !ur) begin
      start_i = 1'b1;
      len_i   = LEN_W'(nlen);
      data1_i = nd1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_txvalid"}, 32'(utmi_txvalid_o), 32'd0);
    check({tag, "_data"}, 32'(utmi_data_o), 32'd0);
    check({tag, "_pop"}, 32'(fifo_pop_o), 32'd0);
    check({tag, "_flush"}, 32'(fifo_flush_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_underrun"}, 32'(underrun_o), 32'd0);
  endtask

  // Main sequence
  initial begin
    bit ur;
    int len;
    int avail;
    #1;
    check_reset_values("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;

    // Zero-length DATA0, then DATA1 ramp, always ready
    rdy_mode = 0;
    send(0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(4, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Same packet with txready toggling each cycle
    rdy_mode = 1;
    send(4, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Underrun: 8 requested, 3 available
    rdy_mode = 0;
    send(8, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    rdy_mode = 1;
    send(8, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of the payload
    rdy_mode = 0;
    prep(8, 1'b1, 8, 1'b0, ur);
    @(negedge clk_i);
    #1;
    start_i = 1'b1;
    len_i   = LEN_W'(8);
    data1_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    fifo_q.delete();
    @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    send(5, 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Stray start pulses while busy are ignored
    rdy_mode = 2;
    send(6, 1'b0, 6, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Start in the done cycle launches the next packet immediately
    rdy_mode = 0;
    send(3, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    send(2, 1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Maximum length
    send(1023, 1'b1, 1023, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Randomized packets
    for (int t = 0; t < 25; t++) begin
      rdy_mode = $urandom_range(0, 2);
      len = $urandom_range(0, 40);
      avail = len;
      if (len > 0 && $urandom_range(0, 5) == 0) avail = $urandom_range(0, len - 1);
      send(len, 1'($urandom_range(0, 1)), avail, 1'b0, 1'($urandom_range(0, 1)),
           1'b0, 1'b0, 0, 1'b0);
    end

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
